dw_conv3x3_mac: RTL and testbench
=================================

Name: dw_conv3x3_mac

Overview:
- Downstream of the 3x3 window generator.
- Captures each valid 3x3 window (all FM_DEPTH channels) and computes a depthwise 3x3 convolution.
- Uses one time-multiplexed signed multiplier per channel; taps are accumulated sequentially over 9 cycles.
- Result is rounded, shifted, saturated to 16 bits, and presented with a one-cycle valid pulse to the next layer stage.

Parameters:
- FM_DEPTH, 64, number of channels (one MAC lane each).
- CORE_SIZE, 9, taps per window (fixed 3x3; only 9 supported).
- ACC_WIDTH, 36, signed accumulator width (32-bit product + 4 growth bits).
- SHIFT, 8, arithmetic right shift applied to the accumulator before saturation (≥1).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- verticle_sync  input  1  start of frame; aborts in-flight work.
- mode_in  input  1  0 = load weights, 1 = calculate.
- weight_valid  input  1  one weight tap per channel present (load mode only).
- weight_in  input  [15:0] x FM_DEPTH  signed weight of current tap, per channel.
- win_valid  input  1  window valid pulse from window generator.
- win_data  input  [15:0] x FM_DEPTH x CORE_SIZE  signed window taps; edge zeros are already applied upstream.
- busy  output  1  MAC in progress.
- overrun  output  1  sticky: a window arrived while busy.
- data_out_valid  output  1  one-cycle result pulse.
- data_out  output  [15:0] x FM_DEPTH  signed result per channel.

Behaviour:
Reset (rstn=0, asynchronous):
- weights, window snapshot, accumulators and data_out all clear to 0.
- FSM goes to IDLE; busy=0, overrun=0, data_out_valid=0, weight tap pointer wp=0.

Weight load (mode_in=0):
- Each cycle with weight_valid=1 writes weight_in[c] into weight[c][wp] for all channels c.
- wp then increments, wrapping 8→0.
- Weights hold their values across verticle_sync and across mode changes; only rstn or a new load changes them.
- While mode_in=1, wp is forced to 0.
- weight_valid is ignored when mode_in=1.

Calculate FSM (mode_in=1): states IDLE, MAC, OUT.
- IDLE:
  - win_valid=1 → snapshot all win_data into internal registers (window is only stable in that cycle).
  - Clear acc, set tap k=0, go to MAC.
- MAC:
  - Each cycle: acc[c] += sext(win[c][k]) * sext(weight[c][k]) (signed 16x16→32, sign-extended to ACC_WIDTH).
  - k increments each cycle; after k=8 is accumulated, go to OUT.
  - MAC lasts exactly 9 cycles.
- OUT:
  - data_out[c] = sat16((acc[c] + 2^(SHIFT-1)) >>> SHIFT), i.e. round half up then arithmetic shift.
  - sat16 clamps to [-32768, 32767].
  - data_out is registered; data_out_valid=1 for exactly this cycle. Return to IDLE.
  - data_out holds its last value until the next OUT.
- Latency: win_valid at cycle T → data_out_valid at cycle T+10. Minimum window spacing without drop is 11 cycles; upstream spacing is ≥16.
- busy=1 in MAC and OUT.

Overrun:
- win_valid=1 in MAC or OUT → that window is dropped, the current computation continues unchanged, and overrun is set.
- overrun clears only on rstn or verticle_sync.
- win_valid in the OUT cycle is also dropped; it is not queued.

Abort:
- verticle_sync=1 or mode_in=0, in any state → FSM to IDLE next cycle, no data_out_valid, acc cleared, data_out retained.
- win_valid in the same cycle as verticle_sync is ignored.

Accumulator range:
- Max |sum| = 9·2^30 < 2^34, so ACC_WIDTH=36 cannot overflow.

Test Plan:
- Load all weights=256 (1.0 at SHIFT=8), window all taps=100 → data_out=900 for every channel, valid exactly 10 cycles after win_valid.
- Weights tap4=256, others 0; window tap4=-5, others 7 → data_out=-5; result for tap4=-3 with weight 128 → (-384+128)>>>8 = -1.
- Saturation: weights all 32767, taps all 32767 → 32767; taps all -32768 with weights 32767 → -32768.
- Overrun: second win_valid 5 cycles after first → single data_out_valid at T+10 with first result, overrun=1; verticle_sync → overrun=0.
- Abort: verticle_sync at cycle T+4 of a MAC → no data_out_valid; next win_valid yields correct fresh result (no stale accumulation).
- Weight wrap and reset: 10 weight_valid pulses with values 1..10 → tap0=10, taps1..8=2..9; async rstn mid-MAC clears busy/valid immediately and weights read 0.

Source files
------------

// File: rtl/dw_conv3x3_mac.sv
// Depthwise 3x3 convolution MAC: one time-multiplexed signed multiplier per channel,
// nine taps accumulated sequentially, then rounded, shifted and saturated to 16 bits.
module dw_conv3x3_mac #(
    parameter int FM_DEPTH  = 64,
    parameter int CORE_SIZE = 9,
    parameter int ACC_WIDTH = 36,
    parameter int SHIFT     = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   verticle_sync,
    input  logic                                   mode_in,
    input  logic                                   weight_valid,
    input  logic [FM_DEPTH-1:0][15:0]              weight_in,
    input  logic                                   win_valid,
    input  logic [FM_DEPTH-1:0][CORE_SIZE-1:0][15:0] win_data,
    output logic                                   busy,
    output logic                                   overrun,
    output logic                                   data_out_valid,
    output logic [FM_DEPTH-1:0][15:0]              data_out
);

    localparam int KW = $clog2(CORE_SIZE);
    localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(1) << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(32768);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_nxt;
    logic [KW-1:0] wp, k;
    logic [FM_DEPTH-1:0][CORE_SIZE-1:0][15:0] weight, win;
    logic signed [ACC_WIDTH-1:0] acc     [FM_DEPTH];
    logic signed [ACC_WIDTH-1:0] acc_sum [FM_DEPTH];
    logic signed [ACC_WIDTH-1:0] rounded [FM_DEPTH];
    logic signed [31:0]          prod    [FM_DEPTH];
    logic [FM_DEPTH-1:0][15:0]   result;
    logic abort, start, last_tap;

    assign abort    = verticle_sync | ~mode_in;
    assign start    = (state == IDLE) & win_valid & ~abort;
    assign last_tap = (state == MAC) & (k == KW'(CORE_SIZE - 1)) & ~abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (win_valid) state_nxt = MAC;
                MAC:     if (k == KW'(CORE_SIZE - 1)) state_nxt = OUT;
                OUT:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != IDLE);
        data_out_valid = (state == OUT);
    end

    // Weights survive frame syncs and mode changes; only reset or a reload touches them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight <= '0;
            wp     <= '0;
        end else if (mode_in) begin
            wp <= '0;
        end else if (weight_valid) begin
            for (int c = 0; c < FM_DEPTH; c++) weight[c][wp] <= weight_in[c];
            wp <= (wp == KW'(CORE_SIZE - 1)) ? '0 : wp + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win     <= '0;
            k       <= '0;
            overrun <= 1'b0;
        end else begin
            if (start) win <= win_data;
            if (start || state != MAC || abort) k <= '0;
            else                                k <= k + 1'b1;
            if (verticle_sync)        overrun <= 1'b0;
            else if (win_valid && busy) overrun <= 1'b1;
        end
    end

    always_comb begin
        for (int c = 0; c < FM_DEPTH; c++) begin
            prod[c]    = $signed(win[c][k]) * $signed(weight[c][k]);
            acc_sum[c] = acc[c] + ACC_WIDTH'(prod[c]);
            rounded[c] = (acc_sum[c] + RND) >>> SHIFT;
            if (rounded[c] > SAT_MAX)      result[c] = 16'h7fff;
            else if (rounded[c] < SAT_MIN) result[c] = 16'h8000;
            else                           result[c] = rounded[c][15:0];
        end
    end

    // data_out is loaded from the final tap's sum so it is already valid in OUT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < FM_DEPTH; c++) acc[c] <= '0;
            data_out <= '0;
        end else begin
            for (int c = 0; c < FM_DEPTH; c++) begin
                if (abort || start)    acc[c] <= '0;
                else if (state == MAC) acc[c] <= acc_sum[c];
            end
            if (last_tap) data_out <= result;
        end
    end

endmodule

// File: tb/tb_dw_conv3x3_mac.sv
// Randomized self-checking bench for dw_conv3x3_mac against a plain-arithmetic convolution model.
module tb_dw_conv3x3_mac;

    localparam int FM = 4;
    localparam int CS = 9;
    localparam int SH = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic verticle_sync = 1'b0;
    logic mode_in = 1'b1;
    logic weight_valid = 1'b0;
    logic [FM-1:0][15:0] weight_in = '0;
    logic win_valid = 1'b0;
    logic [FM-1:0][CS-1:0][15:0] win_data = '0;
    logic busy, overrun, data_out_valid;
    logic [FM-1:0][15:0] data_out;

    int errors = 0;
    int checks = 0;
    int mw [FM][CS];
    int mx [FM][CS];
    int lat, pulses;
    logic [FM-1:0][15:0] dout, prev;

    dw_conv3x3_mac #(.FM_DEPTH(FM), .CORE_SIZE(CS), .ACC_WIDTH(36), .SHIFT(SH)) dut (
        .clk(clk), .rstn(rstn), .verticle_sync(verticle_sync), .mode_in(mode_in),
        .weight_valid(weight_valid), .weight_in(weight_in), .win_valid(win_valid),
        .win_data(win_data), .busy(busy), .overrun(overrun),
        .data_out_valid(data_out_valid), .data_out(data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] ref_out(int c);
        longint s = 0;
        for (int t = 0; t < CS; t++) s += longint'(mx[c][t]) * longint'(mw[c][t]);
        s = (s + (longint'(1) << (SH - 1))) >>> SH;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic int rnd16(int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic load_weights();
        mode_in = 1'b0;
        for (int t = 0; t < CS; t++) begin
            @(posedge clk); #1;
            weight_valid = 1'b1;
            for (int c = 0; c < FM; c++) weight_in[c] = 16'(mw[c][t]);
        end
        @(posedge clk); #1;
        weight_valid = 1'b0;
        weight_in = '0;
        mode_in = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents mx as one window, then runs 20 cycles, optionally injecting a second
    // window or a frame sync at cycle offset n, and records the result pulses.
    task automatic run_window(input int inj_at, input int sync_at,
                              output int lat_o, output int pulses_o,
                              output logic [FM-1:0][15:0] dout_o);
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) win_data[c][t] = 16'(mx[c][t]);
        win_valid = 1'b1;
        lat_o = -1;
        pulses_o = 0;
        dout_o = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            win_valid = (n == inj_at);
            verticle_sync = (n == sync_at);
            for (int c = 0; c < FM; c++)
                for (int t = 0; t < CS; t++) win_data[c][t] = 16'($urandom);
            @(negedge clk);
            if (data_out_valid) begin
                pulses_o++;
                if (lat_o < 0) begin
                    lat_o = n;
                    dout_o = data_out;
                end
            end
        end
        win_valid = 1'b0;
        verticle_sync = 1'b0;
    endtask

    task automatic check_result(input string name);
        checks++;
        if (lat !== 10 || pulses !== 1) begin
            errors++;
            $display("FAIL %s timing: latency=%0d pulses=%0d required latency=10 pulses=1", name, lat, pulses);
        end
        for (int c = 0; c < FM; c++) begin
            checks++;
            if (dout[c] !== ref_out(c)) begin
                errors++;
                $display("FAIL %s ch%0d: got %0d required %0d", name, c,
                         $signed(dout[c]), $signed(ref_out(c)));
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || data_out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b overrun=%b valid=%b data_out=%h required all zero",
                     busy, overrun, data_out_valid, data_out);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) begin mw[c][t] = 256; mx[c][t] = 100; end
        load_weights();
        run_window(0, 0, lat, pulses, dout);
        check_result("identity");
        checks++;
        if (dout[0] !== 16'd900) begin
            errors++;
            $display("FAIL identity const: got %0d required 900", $signed(dout[0]));
        end
    endtask

    task automatic test_center();
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) begin
                mw[c][t] = (t == 4) ? 256 : 0;
                mx[c][t] = (t == 4) ? -5 : 7;
            end
        load_weights();
        run_window(0, 0, lat, pulses, dout);
        check_result("center");
        for (int c = 0; c < FM; c++) begin mw[c][4] = 128; mx[c][4] = -3; end
        load_weights();
        run_window(0, 0, lat, pulses, dout);
        check_result("round_neg");
        checks++;
        if (dout[1] !== 16'hffff) begin
            errors++;
            $display("FAIL round_neg const: got %0d required -1", $signed(dout[1]));
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) begin mw[c][t] = 32767; mx[c][t] = 32767; end
        load_weights();
        run_window(0, 0, lat, pulses, dout);
        check_result("sat_pos");
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) mx[c][t] = -32768;
        run_window(0, 0, lat, pulses, dout);
        check_result("sat_neg");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int lim = (it % 2 == 0) ? 300 : 32767;
            for (int c = 0; c < FM; c++)
                for (int t = 0; t < CS; t++) begin
                    mw[c][t] = rnd16(lim);
                    mx[c][t] = rnd16(32767);
                end
            load_weights();
            run_window(0, 0, lat, pulses, dout);
            check_result($sformatf("random%0d", it));
        end
    endtask

    task automatic test_overrun();
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) mx[c][t] = rnd16(2000);
        run_window(5, 0, lat, pulses, dout);
        check_result("overrun_mac");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        @(posedge clk); #1;
        verticle_sync = 1'b1;
        @(posedge clk); #1;
        verticle_sync = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        run_window(10, 0, lat, pulses, dout);
        check_result("overrun_out");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_out_set: got %b required 1", overrun);
        end
        @(posedge clk); #1;
        verticle_sync = 1'b1;
        @(posedge clk); #1;
        verticle_sync = 1'b0;
    endtask

    task automatic test_abort();
        prev = data_out;
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) mx[c][t] = rnd16(5000);
        run_window(0, 4, lat, pulses, dout);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_pulse: got %0d pulses required 0", pulses);
        end
        checks++;
        if (data_out !== prev) begin
            errors++;
            $display("FAIL abort_hold: got %h required %h", data_out, prev);
        end
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) mx[c][t] = rnd16(5000);
        run_window(0, 0, lat, pulses, dout);
        check_result("after_abort");
    endtask

    task automatic test_weight_wrap();
        mode_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            weight_valid = 1'b1;
            for (int c = 0; c < FM; c++) begin
                weight_in[c] = 16'(c * 100 + i);
                mw[c][(i - 1) % CS] = c * 100 + i;
            end
        end
        @(posedge clk); #1;
        weight_valid = 1'b0;
        mode_in = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < CS; t++) begin
            for (int c = 0; c < FM; c++)
                for (int u = 0; u < CS; u++) mx[c][u] = (u == t) ? 256 : 0;
            run_window(0, 0, lat, pulses, dout);
            check_result($sformatf("wrap_tap%0d", t));
        end
        checks++;
        if (mw[2][0] !== 210) begin
            errors++;
            $display("FAIL wrap_model: tap0 got %0d required 210", mw[2][0]);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) mx[c][t] = rnd16(3000);
        win_valid = 1'b1;
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) win_data[c][t] = 16'(mx[c][t]);
        @(posedge clk); #1;
        win_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_busy: got %b required 1", busy);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b data_out=%h required 0 0 0",
                     busy, data_out_valid, data_out);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < FM; c++)
            for (int t = 0; t < CS; t++) begin mw[c][t] = 0; mx[c][t] = rnd16(32767); end
        run_window(0, 0, lat, pulses, dout);
        check_result("weights_cleared");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_center();
        test_saturation();
        test_random();
        test_overrun();
        test_abort();
        test_weight_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
